// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB stepping with
// memory handshakes, ack timeouts, sticky error flags and a retired-instruction counter.
module multicycle_ctrl #(
    parameter int          TIMEOUT     = 16,
    parameter logic [31:0] INSTRET_RST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  ir_opcode,
    input  logic        br_taken,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pc_sel,
    output logic        alu_src_b,
    output logic [1:0]  alu_op,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        illegal,
    output logic        bus_err,
    output logic [31:0] instret
);

    localparam int              CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;

    logic is_load, is_store, is_opimm, is_op, is_lui, is_branch, legal;
    logic [1:0] alu_op_cls;
    logic       alu_src_cls;

    assign is_load   = (ir_opcode == 7'b0000011);
    assign is_store  = (ir_opcode == 7'b0100011);
    assign is_opimm  = (ir_opcode == 7'b0010011);
    assign is_op     = (ir_opcode == 7'b0110011);
    assign is_lui    = (ir_opcode == 7'b0110111);
    assign is_branch = (ir_opcode == 7'b1100011);
    assign legal     = is_load | is_store | is_opimm | is_op | is_lui | is_branch;

    // ALU setup per instruction class; shared by EXEC and WB so it stays stable.
    always_comb begin
        alu_op_cls  = 2'b00;
        alu_src_cls = 1'b0;
        if (is_load || is_store) begin
            alu_src_cls = 1'b1;
        end else if (is_opimm) begin
            alu_op_cls  = 2'b10;
            alu_src_cls = 1'b1;
        end else if (is_op) begin
            alu_op_cls  = 2'b10;
        end else if (is_branch) begin
            alu_op_cls  = 2'b01;
        end
    end

    always_comb begin
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = 1'b0;
        alu_src_b = 1'b0;
        alu_op    = 2'b00;
        rf_we     = 1'b0;
        wb_sel    = 2'b00;
        case (state)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_we    = imem_ack;
            end
            S_EXEC: begin
                alu_op    = alu_op_cls;
                alu_src_b = alu_src_cls;
                if (is_branch) begin
                    pc_we  = 1'b1;
                    pc_sel = br_taken;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_store;
                pc_we    = is_store & dmem_ack;
            end
            S_WB: begin
                alu_op    = alu_op_cls;
                alu_src_b = alu_src_cls;
                rf_we     = 1'b1;
                pc_we     = 1'b1;
                if (is_load)
                    wb_sel = 2'b01;
                else if (is_lui)
                    wb_sel = 2'b10;
            end
            default: ;
        endcase
    end

    // An ack on the last allowed wait cycle takes priority over the timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            illegal  <= 1'b0;
            bus_err  <= 1'b0;
            instret  <= INSTRET_RST;
        end else begin
            if (pc_we)
                instret <= instret + 32'd1;
            case (state)
                S_IDLE: begin
                    state    <= S_FETCH;
                    wait_cnt <= '0;
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        state <= S_DECODE;
                    end else if (wait_cnt == CNT_LAST) begin
                        state   <= S_TRAP;
                        bus_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_DECODE: begin
                    if (legal) begin
                        state <= S_EXEC;
                    end else begin
                        state   <= S_TRAP;
                        illegal <= 1'b1;
                    end
                end
                S_EXEC: begin
                    wait_cnt <= '0;
                    if (is_load || is_store)
                        state <= S_MEM;
                    else if (is_branch)
                        state <= S_FETCH;
                    else
                        state <= S_WB;
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        wait_cnt <= '0;
                        state    <= is_store ? S_FETCH : S_WB;
                    end else if (wait_cnt == CNT_LAST) begin
                        state   <= S_TRAP;
                        bus_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_WB: begin
                    state    <= S_FETCH;
                    wait_cnt <= '0;
                end
                S_TRAP:  state <= S_TRAP;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: instruction classes, memory waits, timeouts,
// illegal opcode, async reset mid-access and retired-count wrap.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  ir_opcode;
    logic        br_taken, imem_ack, dmem_ack;
    logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, alu_src_b, rf_we;
    logic [1:0]  alu_op, wb_sel;
    logic        illegal, bus_err;
    logic [31:0] instret;

    logic        w_imem_req, w_dmem_req, w_dmem_we, w_ir_we, w_pc_we, w_pc_sel, w_alu_src_b, w_rf_we;
    logic [1:0]  w_alu_op, w_wb_sel;
    logic        w_illegal, w_bus_err;
    logic [31:0] w_instret;

    int ncmp = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .ir_opcode(ir_opcode), .br_taken(br_taken),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .rf_we(rf_we), .wb_sel(wb_sel),
        .illegal(illegal), .bus_err(bus_err), .instret(instret)
    );

    // Second instance with the counter preloaded to all-ones to observe the wrap.
    multicycle_ctrl #(.TIMEOUT(4), .INSTRET_RST(32'hFFFF_FFFF)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .ir_opcode(ir_opcode), .br_taken(br_taken),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(w_imem_req), .dmem_req(w_dmem_req),
        .dmem_we(w_dmem_we), .ir_we(w_ir_we), .pc_we(w_pc_we), .pc_sel(w_pc_sel),
        .alu_src_b(w_alu_src_b), .alu_op(w_alu_op), .rf_we(w_rf_we), .wb_sel(w_wb_sel),
        .illegal(w_illegal), .bus_err(w_bus_err), .instret(w_instret)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1; ir_opcode = 7'd0; br_taken = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst_pc_we", {31'd0, pc_we}, 32'd0);
        chk("rst_flags", {30'd0, illegal, bus_err}, 32'd0);
        chk("rst_instret", instret, 32'd0);
        chk("rst_w_instret", w_instret, 32'hFFFF_FFFF);
        #9 rst_n = 1'b1;
        #2 chk("idle_imem_req", {31'd0, imem_req}, 32'd0);

        // op-imm addi x1,x0,5, zero-wait fetch
        tick(); imem_ack = 1'b1; ir_opcode = 7'b0010011; #1;
        chk("opimm_fetch_req", {31'd0, imem_req}, 32'd1);
        chk("opimm_fetch_irwe", {31'd0, ir_we}, 32'd1);
        tick(); imem_ack = 1'b0; #1;
        chk("opimm_dec_enables", {28'd0, imem_req, ir_we, pc_we, rf_we}, 32'd0);
        tick(); #1;
        chk("opimm_exec_alu", {29'd0, alu_op, alu_src_b}, 32'b101);
        chk("opimm_exec_pcwe", {31'd0, pc_we}, 32'd0);
        tick(); #1;
        chk("opimm_wb_ctl", {27'd0, rf_we, wb_sel, pc_we, pc_sel}, 32'b10010);
        chk("opimm_wb_instret", instret, 32'd0);
        tick(); #1;
        chk("opimm_next_fetch", {30'd0, imem_req, pc_we}, 32'b10);
        chk("opimm_instret", instret, 32'd1);
        chk("wrap_instret", w_instret, 32'd0);

        // load with dmem_ack on the 4th MEM cycle
        imem_ack = 1'b1; ir_opcode = 7'b0000011; #1;
        chk("ld_fetch_irwe", {31'd0, ir_we}, 32'd1);
        tick(); imem_ack = 1'b0; #1;
        tick(); #1;
        chk("ld_exec", {28'd0, alu_op, alu_src_b, dmem_req}, 32'b0010);
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            chk("ld_mem_wait", {29'd0, dmem_req, dmem_we, pc_we}, 32'b100);
        end
        tick(); dmem_ack = 1'b1; #1;
        chk("ld_mem_ack", {28'd0, dmem_req, dmem_we, pc_we, rf_we}, 32'b1000);
        tick(); dmem_ack = 1'b0; #1;
        chk("ld_wb", {27'd0, dmem_req, wb_sel, rf_we, pc_we}, 32'b00111);
        tick(); #1;
        chk("ld_instret", instret, 32'd2);

        // store, zero-wait
        imem_ack = 1'b1; ir_opcode = 7'b0100011; #1;
        tick(); imem_ack = 1'b0; #1;
        tick(); #1;
        chk("st_exec_srcb", {31'd0, alu_src_b}, 32'd1);
        tick(); dmem_ack = 1'b1; #1;
        chk("st_mem", {27'd0, dmem_req, dmem_we, pc_we, pc_sel, rf_we}, 32'b11100);
        tick(); dmem_ack = 1'b0; #1;
        chk("st_next_fetch", {31'd0, imem_req}, 32'd1);
        chk("st_instret", instret, 32'd3);

        // lui
        imem_ack = 1'b1; ir_opcode = 7'b0110111; #1;
        tick(); imem_ack = 1'b0; #1;
        tick(); #1;
        chk("lui_exec", {30'd0, pc_we, rf_we}, 32'd0);
        tick(); #1;
        chk("lui_wb", {28'd0, wb_sel, rf_we, pc_we}, 32'b1011);
        tick(); #1;
        chk("lui_instret", instret, 32'd4);

        // branch taken, then not taken
        imem_ack = 1'b1; ir_opcode = 7'b1100011; #1;
        tick(); imem_ack = 1'b0; #1;
        tick(); br_taken = 1'b1; #1;
        chk("br1_exec", {26'd0, pc_we, pc_sel, alu_op, alu_src_b, rf_we}, 32'b110100);
        chk("br1_dmem_req", {31'd0, dmem_req}, 32'd0);
        tick(); br_taken = 1'b0; #1;
        chk("br1_fetch", {31'd0, imem_req}, 32'd1);
        chk("br1_instret", instret, 32'd5);
        imem_ack = 1'b1; #1;
        tick(); imem_ack = 1'b0; #1;
        tick(); #1;
        chk("br0_exec", {28'd0, pc_we, pc_sel, rf_we, dmem_req}, 32'b1000);
        tick(); #1;
        chk("br0_instret", instret, 32'd6);

        // fetch acked on the 4th request cycle (limit), then illegal opcode
        ir_opcode = 7'h7F;
        for (int i = 0; i < 3; i++) begin
            chk("late_fetch_req", {31'd0, imem_req}, 32'd1);
            tick();
        end
        imem_ack = 1'b1; #1;
        chk("late_fetch_ack", {29'd0, imem_req, ir_we, bus_err}, 32'b110);
        tick(); imem_ack = 1'b0; #1;
        chk("ill_decode", {30'd0, imem_req, bus_err}, 32'd0);
        tick(); #1;
        chk("ill_trap", {28'd0, illegal, imem_req, dmem_req, pc_we}, 32'b1000);
        chk("ill_instret", instret, 32'd6);
        tick(); tick(); #1;
        chk("ill_sticky", {30'd0, illegal, imem_req}, 32'b10);
        rst_n = 1'b0; #1;
        chk("ill_rst_clear", {30'd0, illegal, bus_err}, 32'd0);
        chk("rst2_instret", instret, 32'd0);
        chk("rst2_w_instret", w_instret, 32'hFFFF_FFFF);
        #1 rst_n = 1'b1;

        // fetch timeout
        tick(); #1;
        for (int i = 0; i < 4; i++) begin
            chk("to_fetch_req", {31'd0, imem_req}, 32'd1);
            tick();
        end
        #1;
        chk("to_trap", {28'd0, bus_err, illegal, imem_req, dmem_req}, 32'b1000);
        tick(); #1;
        chk("to_sticky", {30'd0, bus_err, imem_req}, 32'b10);
        rst_n = 1'b0; #1;
        chk("to_rst_clear", {31'd0, bus_err}, 32'd0);
        #1 rst_n = 1'b1;

        // async reset during MEM
        tick(); imem_ack = 1'b1; ir_opcode = 7'b0000011; #1;
        tick(); imem_ack = 1'b0; #1;
        tick(); #1;
        tick(); #1;
        chk("ar_mem_req", {31'd0, dmem_req}, 32'd1);
        rst_n = 1'b0; #1;
        chk("ar_req_drop", {30'd0, dmem_req, imem_req}, 32'd0);
        chk("ar_instret", instret, 32'd0);
        #1 rst_n = 1'b1;
        tick(); #1;
        chk("ar_refetch", {30'd0, imem_req, dmem_req}, 32'b10);
        chk("ar_instret_after", instret, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control sequencer for the RV32I core datapath. It steps each instruction through fetch, decode, execute, memory and write-back. It handshakes with instruction and data memory and produces the per-cycle enables and selects for the PC, IR, ALU, register file and write-back mux. It sits beside the datapath and consumes the latched IR opcode plus the branch comparator result, so the shared ALU and immediate generator are reused across states.

## Interface
Parameters:
- TIMEOUT, 16: max cycles a memory request waits for ack before bus error (≥1)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- ir_opcode  in  7  IR[6:0]; valid from DECODE onward
- br_taken  in  1  datapath branch-condition result; valid in EXEC
- imem_ack  in  1  instruction word valid this cycle
- dmem_ack  in  1  data access complete this cycle
- imem_req  out  1  instruction fetch request
- dmem_req  out  1  data access request
- dmem_we  out  1  data write (stores)
- ir_we  out  1  load IR
- pc_we  out  1  update PC
- pc_sel  out  1  0 = PC+4, 1 = PC+imm
- alu_src_b  out  1  0 = rs2, 1 = immediate
- alu_op  out  2  00 add, 01 compare/sub, 10 funct-decoded
- rf_we  out  1  register-file write
- wb_sel  out  2  00 ALU, 01 mem data, 10 immediate
- illegal  out  1  sticky: unsupported opcode
- bus_err  out  1  sticky: memory ack timeout
- instret  out  32  retired-instruction count

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP. Reset enters IDLE. IDLE always goes to FETCH next cycle.
- Outputs are decoded from state and ir_opcode. Any output not listed for a state is 0.
- FETCH: imem_req=1, held until imem_ack. On the ack cycle ir_we=1 and the next state is DECODE.
- DECODE: one cycle, register-file read, no enables.
  - Supported opcodes: 0000011 load, 0100011 store, 0010011 op-imm, 0110011 op, 0110111 lui, 1100011 branch.
  - Any other opcode → TRAP with illegal set.
- EXEC settings by class:
  - load/store: alu_op=00, alu_src_b=1 → MEM.
  - op-imm: alu_op=10, alu_src_b=1 → WB.
  - op: alu_op=10, alu_src_b=0 → WB.
  - lui: → WB.
  - branch: alu_op=01, alu_src_b=0, pc_we=1, pc_sel=br_taken → FETCH.
- MEM: dmem_req=1, held until dmem_ack. dmem_we=1 for stores, 0 for loads.
  - On the ack cycle: a store asserts pc_we=1 (pc_sel=0) → FETCH; a load → WB.
- WB: rf_we=1, pc_we=1, pc_sel=0 → FETCH.
  - wb_sel: 01 for load, 10 for lui, 00 otherwise.
  - alu_op and alu_src_b hold their EXEC values in WB.
- x0 suppression is handled by the register file. rf_we is asserted regardless of rd.
- pc_we pulses exactly once per retired instruction. instret increments in that same cycle and wraps 0xFFFFFFFF→0.
- Timeout:
  - A wait counter clears on entry to FETCH or MEM and counts each cycle the request is unacknowledged.
  - An ack on cycle k, 1≤k≤TIMEOUT, is accepted.
  - If TIMEOUT cycles elapse with no ack → TRAP with bus_err=1.
  - When an ack and the limit coincide, the ack wins.
- TRAP: all enables and requests 0. The sticky flag holds. Only reset exits.

## Timing
- Reset (async assert, immediate): state=IDLE; every output 0, including illegal, bus_err and instret=0.
- Reset release is synchronous to clk. The first FETCH is on the cycle after the first rising edge.
- Reset asserted mid-access drops imem_req/dmem_req combinationally. The in-flight instruction does not retire.
- Cycles per instruction with zero-wait acks (FETCH through final state):
  - branch: 3
  - op, op-imm, lui, store: 4
  - load: 5
- Each memory wait cycle adds 1.
- Requests stay high continuously from state entry through the ack cycle. They deassert the cycle after the ack.
- An ack arriving while no request is outstanding is ignored.

## Test plan
- Reset, then op-imm 0x00500093 with imem_ack on the first FETCH cycle:
  - Sequence IDLE,FETCH,DECODE,EXEC,WB.
  - rf_we=1 and wb_sel=00 in WB; a single pc_we pulse; instret=1.
- Load with dmem_ack delayed 3 cycles:
  - dmem_req high 4 cycles, dmem_we=0.
  - WB has wb_sel=01.
  - Total 8 cycles, pc_we once.
- Branch with br_taken=1 in EXEC, then a repeat with br_taken=0:
  - pc_we=1 in EXEC, pc_sel=1 then 0.
  - No rf_we, no dmem_req.
- Timeouts with TIMEOUT=4:
  - imem_ack withheld → TRAP after 4 request cycles, bus_err=1, all requests 0.
  - Separately, ack on cycle 4 → accepted.
- Opcode 0x7F:
  - TRAP after DECODE, illegal=1 sticky, instret unchanged.
  - rst_n low clears the flag.
- Async reset asserted during MEM:
  - dmem_req falls without a clock edge; instret unchanged.
  - After release, fetch restarts.
  - Also preload instret=0xFFFFFFFF and check it wraps to 0.
